pram_sram_verify: RTL and testbench



---
 rtl/pram_sram_pkg.sv | 27 ++
 rtl/pram_sram_verify_wait_counter.sv | 28 ++
 rtl/pram_sram_verify.sv | 167 ++++++++++++++++
 tb/tb_pram_sram_verify.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pram_sram_pkg.sv
// Shared definitions for the SRAM pattern writer and read-back checker.
package pram_sram_pkg;

    // Width of the test pattern carried in the upper bits of every word
    localparam int unsigned PAT_W = 6;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StAddr   = 3'd1,
        StWait   = 3'd2,
        StSample = 3'd3,
        StDone   = 3'd4
    } state_e;

    // Expected word {pat, addr[data_w-7:0]} in a 64-bit container.
    // Address bits above the low data_w-6 are dropped and narrower
    // addresses come out zero-extended. The caller passes its real data
    // width, so bits above data_w-1 are always zero.
    function automatic logic [63:0] exp_word(input logic [PAT_W-1:0] pat,
                                             input logic [63:0]      addr,
                                             input int unsigned      data_w);
        logic [63:0] mask;
        mask = (64'd1 << (data_w - PAT_W)) - 64'd1;
        return ({58'd0, pat} << (data_w - PAT_W)) | (addr & mask);
    endfunction

endpackage

// File: rtl/pram_sram_verify_wait_counter.sv
// Loadable down-counter with a zero flag, used to time SRAM read access.
module pram_wait_counter #(
    parameter int unsigned W = 2
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    logic [W-1:0] count_q;

    // Load takes priority over decrement; the count never goes below zero
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_val;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - W'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/pram_sram_verify.sv
// SRAM read-back checker: sweeps all addresses, compares each read word with
// the pattern/address word and reports error count, first failing address and
// a pass/fail verdict.
module pram_sram_verify
    import pram_sram_pkg::*;
#(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              start,
    input  logic              abort,
    input  logic [PAT_W-1:0]  pattern,
    input  logic [DATA_W-1:0] sram_data,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              oe,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_count,
    output logic [ADDR_W-1:0] first_fail_addr
);

    // The counter is loaded with WAIT_CYCLES-1 and WAIT is left on the cycle
    // it reads zero, which gives exactly WAIT_CYCLES cycles in WAIT.
    localparam int unsigned     CNT_W    = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [ADDR_W-1:0]  ffa_q, ffa_d;
    logic [15:0]        err_q, err_d;
    logic [PAT_W-1:0]   pat_q, pat_d;
    logic               fail_q, fail_d;
    logic               pass_q, pass_d;

    logic               cnt_zero;
    logic [63:0]        exp_full;
    logic               mismatch;
    logic               last_addr;

    pram_wait_counter #(
        .W (CNT_W)
    ) u_wait_counter (
        .clk      (clk),
        .clr      (clr),
        .load     (state_q == StAddr),
        .load_val (CNT_LOAD),
        .dec      (state_q == StWait),
        .zero     (cnt_zero)
    );

    // Compare against the full-width expected word so no bits go unused
    assign exp_full  = exp_word(pat_q, 64'(addr_q), DATA_W);
    assign mismatch  = (64'(sram_data) != exp_full);
    assign last_addr = &addr_q;

    // State and result registers
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= StIdle;
            addr_q  <= '0;
            ffa_q   <= '0;
            err_q   <= '0;
            pat_q   <= '0;
            fail_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            ffa_q   <= ffa_d;
            err_q   <= err_d;
            pat_q   <= pat_d;
            fail_q  <= fail_d;
            pass_q  <= pass_d;
        end
    end

    // Next-state, sweep bookkeeping and compare logic
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        ffa_d   = ffa_q;
        err_d   = err_q;
        pat_d   = pat_q;
        fail_d  = fail_q;
        pass_d  = pass_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    pat_d   = pattern;
                    addr_d  = '0;
                    err_d   = '0;
                    ffa_d   = '0;
                    fail_d  = 1'b0;
                    pass_d  = 1'b0;
                    state_d = StAddr;
                end
            end
            StAddr: begin
                if (abort) begin
                    fail_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    state_d = (WAIT_CYCLES == 0) ? StSample : StWait;
                end
            end
            StWait: begin
                if (abort) begin
                    fail_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = StDone;
                end else if (cnt_zero) begin
                    state_d = StSample;
                end
            end
            StSample: begin
                // Abort discards this cycle's compare, even on the last address
                if (abort) begin
                    fail_d  = 1'b1;
                    pass_d  = 1'b0;
                    state_d = StDone;
                end else begin
                    if (mismatch) begin
                        if (err_q != 16'hFFFF) begin
                            err_d = err_q + 16'd1;
                        end
                        if (!fail_q) begin
                            ffa_d  = addr_q;
                            fail_d = 1'b1;
                        end
                    end
                    if (last_addr) begin
                        pass_d  = ~fail_d;
                        state_d = StDone;
                    end else begin
                        addr_d  = addr_q + ADDR_W'(1);
                        state_d = StAddr;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        oe   = (state_q == StAddr) || (state_q == StWait) || (state_q == StSample);
        busy = oe;
        done = (state_q == StDone);
    end

    assign sram_addr       = addr_q;
    assign err_count       = err_q;
    assign first_fail_addr = ffa_q;
    assign pass            = pass_q;

endmodule

// File: tb/tb_pram_sram_verify.sv
// Scoreboard bench for the SRAM read-back checker (ADDR_W=4, DATA_W=16).
module tb_pram_sram_verify;

    localparam int unsigned AW = 4;
    localparam int unsigned DW = 16;

    typedef struct {
        logic        pass;
        logic [15:0] err;
        logic [3:0]  ffa;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          clr;
    logic          start_a, abort_a, start_b, abort_b;
    logic [5:0]    pat_a, pat_b, model_pat_a;
    logic          corrupt;
    logic [DW-1:0] data_a, data_b;
    logic [AW-1:0] addr_a, addr_b, ffa_a, ffa_b;
    logic          oe_a, busy_a, done_a, pass_a;
    logic          oe_b, busy_b, done_b, pass_b;
    logic [15:0]   err_a, err_b;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   acc;
    exp_t q_a[$];
    exp_t q_b[$];

    always @(posedge clk) cyc <= cyc + 1;

    // SRAM models: return {pattern, zero-extended address}, optionally corrupted
    always_comb begin
        data_a = {model_pat_a, 6'd0, addr_a};
        if (corrupt && (addr_a == 4'd5 || addr_a == 4'd9)) data_a = data_a ^ 16'h0100;
        data_b = {pat_b, 6'd0, addr_b};
    end

    pram_sram_verify #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_CYCLES (2)
    ) u_dut_a (
        .clk             (clk),
        .clr             (clr),
        .start           (start_a),
        .abort           (abort_a),
        .pattern         (pat_a),
        .sram_data       (data_a),
        .sram_addr       (addr_a),
        .oe              (oe_a),
        .busy            (busy_a),
        .done            (done_a),
        .pass            (pass_a),
        .err_count       (err_a),
        .first_fail_addr (ffa_a)
    );

    pram_sram_verify #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .WAIT_CYCLES (0)
    ) u_dut_b (
        .clk             (clk),
        .clr             (clr),
        .start           (start_b),
        .abort           (abort_b),
        .pattern         (pat_b),
        .sram_data       (data_b),
        .sram_addr       (addr_b),
        .oe              (oe_b),
        .busy            (busy_b),
        .done            (done_b),
        .pass            (pass_b),
        .err_count       (err_b),
        .first_fail_addr (ffa_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pop an expected verdict on every done pulse
    always @(negedge clk) begin
        exp_t e;
        if (done_a === 1'b1) begin
            if (q_a.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL a_spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = q_a.pop_front();
                check("a_pass", 32'(pass_a), 32'(e.pass));
                check("a_err_count", 32'(err_a), 32'(e.err));
                check("a_first_fail", 32'(ffa_a), 32'(e.ffa));
                check("a_done_cycle", cyc, e.cyc);
            end
        end
        if (done_b === 1'b1) begin
            if (q_b.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL b_spurious_done: got done at cycle %0d expected none", cyc);
            end else begin
                e = q_b.pop_front();
                check("b_pass", 32'(pass_b), 32'(e.pass));
                check("b_err_count", 32'(err_b), 32'(e.err));
                check("b_first_fail", 32'(ffa_b), 32'(e.ffa));
                check("b_done_cycle", cyc, e.cyc);
            end
        end
    end

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done(input bit sel_b, input int budget);
        int k = 0;
        while (((sel_b ? done_b : done_a) !== 1'b1) && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (k >= budget) begin
            n_tests++;
            n_fail++;
            $display("FAIL wait_done: got no done within %0d cycles expected a pulse", budget);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        clr = 1'b1; start_a = 1'b0; abort_a = 1'b0; start_b = 1'b0; abort_b = 1'b0;
        pat_a = '0; pat_b = '0; model_pat_a = '0; corrupt = 1'b0;
        @(negedge clk); @(negedge clk);
        // Reset values
        check("rst_oe", 32'(oe_a), 0);
        check("rst_busy", 32'(busy_a), 0);
        check("rst_done", 32'(done_a), 0);
        check("rst_pass", 32'(pass_a), 0);
        check("rst_err", 32'(err_a), 0);
        check("rst_ffa", 32'(ffa_a), 0);
        check("rst_addr", 32'(addr_a), 0);
        clr = 1'b0;
        @(negedge clk);

        // Clean sweep, pattern 2A
        pat_a = 6'h2A; model_pat_a = 6'h2A;
        start_a = 1'b1; acc = cyc + 1;
        q_a.push_back('{pass: 1'b1, err: 16'd0, ffa: 4'd0, cyc: acc + 64});
        @(negedge clk); start_a = 1'b0;
        check("sweep_oe", 32'(oe_a), 1);
        check("sweep_busy", 32'(busy_a), 1);
        wait_done(1'b0, 100);
        @(negedge clk);
        check("post_done_oe", 32'(oe_a), 0);
        check("post_done_busy", 32'(busy_a), 0);
        check("post_done_pass_held", 32'(pass_a), 1);

        // Corrupted words at 5 and 9
        corrupt = 1'b1;
        start_a = 1'b1; acc = cyc + 1;
        q_a.push_back('{pass: 1'b0, err: 16'd2, ffa: 4'd5, cyc: acc + 64});
        @(negedge clk); start_a = 1'b0;
        wait_done(1'b0, 100);
        corrupt = 1'b0;
        @(negedge clk);

        // Abort in WAIT of address 3; a second start mid-sweep is ignored
        start_a = 1'b1; acc = cyc + 1;
        q_a.push_back('{pass: 1'b0, err: 16'd0, ffa: 4'd0, cyc: acc + 14});
        @(negedge clk); start_a = 1'b0;
        wait_cyc(acc + 5);
        start_a = 1'b1;
        @(negedge clk); start_a = 1'b0;
        wait_cyc(acc + 13);
        check("abort_addr", 32'(addr_a), 3);
        abort_a = 1'b1;
        @(negedge clk); abort_a = 1'b0;
        check("abort_busy", 32'(busy_a), 0);
        check("abort_err_held", 32'(err_a), 0);
        @(negedge clk);

        // Asynchronous clear at address 7: no done pulse
        start_a = 1'b1; acc = cyc + 1;
        @(negedge clk); start_a = 1'b0;
        wait_cyc(acc + 28);
        check("clr_pre_addr", 32'(addr_a), 7);
        #2 clr = 1'b1;
        #1;
        check("clr_oe", 32'(oe_a), 0);
        check("clr_busy", 32'(busy_a), 0);
        check("clr_addr", 32'(addr_a), 0);
        check("clr_done", 32'(done_a), 0);
        @(negedge clk); clr = 1'b0;
        @(negedge clk);
        start_a = 1'b1; acc = cyc + 1;
        q_a.push_back('{pass: 1'b1, err: 16'd0, ffa: 4'd0, cyc: acc + 64});
        @(negedge clk); start_a = 1'b0;
        wait_done(1'b0, 100);
        @(negedge clk);

        // start held high: restart one idle cycle after each done, pattern re-latched
        pat_a = 6'h01; model_pat_a = 6'h01;
        start_a = 1'b1; acc = cyc + 1;
        q_a.push_back('{pass: 1'b1, err: 16'd0, ffa: 4'd0, cyc: acc + 64});
        q_a.push_back('{pass: 1'b1, err: 16'd0, ffa: 4'd0, cyc: acc + 130});
        @(negedge clk);
        wait_done(1'b0, 100);
        pat_a = 6'h02; model_pat_a = 6'h02;
        @(negedge clk);
        check("held_idle_gap", 32'(busy_a), 0);
        @(negedge clk);
        check("held_restart", 32'(busy_a), 1);
        wait_done(1'b0, 100);
        start_a = 1'b0;
        @(negedge clk); @(negedge clk);
        check("held_stop", 32'(busy_a), 0);

        // WAIT_CYCLES=0: two cycles per address
        pat_b = 6'h15;
        start_b = 1'b1; acc = cyc + 1;
        q_b.push_back('{pass: 1'b1, err: 16'd0, ffa: 4'd0, cyc: acc + 32});
        @(negedge clk); start_b = 1'b0;
        wait_cyc(acc + 2);
        check("w0_addr_step", 32'(addr_b), 1);
        wait_done(1'b1, 100);
        @(negedge clk);

        check("a_queue_drained", 32'(q_a.size()), 0);
        check("b_queue_drained", 32'(q_b.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
